cmd_exec_ctrl: RTL and testbench
================================

// Module: cmd_exec_ctrl
// PURPOSE
//  Sequencer between the command FIFO read side and the register bus. Pops one
//  command at a time and issues it as a register read or write. Waits for ack
//  or timeout, then presents one response to the UART TX formatter.
//  Only one command is in flight; the FIFO absorbs UART bursts meanwhile.
// PARAMETERS
//  ADDR_W       8    register address width
//  DATA_W       32   register data width
//  TIMEOUT_CYC  255  max cycles reg_req is held without reg_ack (>=2)
// PORTS
//  clk          in   1       system clock
//  rst          in   1       synchronous active-high reset
//  en           in   1       1 = may pop new commands; 0 = finish in-flight, then idle
//  fifo_valid   in   1       FIFO non-empty; head fields valid (show-ahead)
//  fifo_op      in   2       head opcode: 00 READ, 01 WRITE, 1x illegal
//  fifo_addr    in   ADDR_W  head register address
//  fifo_wdata   in   DATA_W  head write data
//  fifo_rd_en   out  1       pop strobe, one cycle per command
//  reg_req      out  1       bus request, held until ack/timeout
//  reg_we       out  1       1 = write, 0 = read
//  reg_addr     out  ADDR_W  bus address
//  reg_wdata    out  DATA_W  bus write data
//  reg_ack      in   1       bus completion, 1-cycle pulse
//  reg_rdata    in   DATA_W  read data, valid with reg_ack
//  rsp_valid    out  1       response available
//  rsp_ready    in   1       consumer accepts response
//  rsp_status   out  2       00 OK, 01 TIMEOUT, 10 BAD_OP
//  rsp_data     out  DATA_W  read data (OK READ), else 0
//  busy         out  1       state != IDLE
//  timeout_cnt  out  8       saturating count of TIMEOUT responses
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; latched cmd, timer, timeout_cnt cleared.
//  - fifo_rd_en = (state==IDLE) & en & fifo_valid (combinational).
//    On that edge, latch op/addr/wdata.
//    Legal op -> REQ; illegal op -> RESP with BAD_OP, no bus access.
//  - REQ: reg_req=1 with reg_we/addr/wdata from latch, stable until exit.
//    Timer clears on entry and counts each REQ cycle.
//    Ack is accepted in the first REQ cycle (zero-wait slave).
//    - reg_ack: capture rdata (READ) or 0 (WRITE), status OK -> RESP.
//    - No ack in the TIMEOUT_CYC-th REQ cycle: status TIMEOUT, data 0 -> RESP.
//      timeout_cnt += 1, saturating at 255.
//    - An ack in that same final cycle wins: status OK.
//  - RESP: rsp_valid=1; status/data stable until rsp_ready.
//    On rsp_valid & rsp_ready -> IDLE. A pop can happen the following cycle.
//  - reg_ack outside REQ is ignored.
//  - en low mid-command does not abort it; it only blocks the next pop.
//  - Latency (ack at REQ cycle k, rsp_ready=1):
//    pop @t, reg_req @t+1..t+k, rsp_valid @t+k+1.
//    Back-to-back throughput is one command per k+2 cycles.
//  - rst mid-command: next edge is IDLE, reg_req and rsp_valid drop.
//    The popped command is discarded, not re-queued.
// TESTING
//  1 WRITE a=0x10 d=0xDEADBEEF, ack 3 cycles after req
//    -> one fifo_rd_en pulse; reg_req 3 cycles, we=1, addr/wdata stable;
//       rsp OK data 0 one cycle after ack.
//  2 READ a=0x04, ack same cycle as req, rdata=0x12345678
//    -> rsp_valid 2 cycles after pop; OK, data 0x12345678.
//  3 TIMEOUT_CYC=16, READ, no ack
//    -> reg_req exactly 16 cycles; rsp TIMEOUT data 0; timeout_cnt=1.
//    Repeat 300x -> timeout_cnt saturates at 255.
//  4 Three commands queued, rsp_ready low 10 cycles on the first
//    -> no second pop until the first handshake; three ordered responses;
//       no pop while busy.
//  5 op=2'b11 -> no reg_req; rsp BAD_OP in cycle after pop.
//    en=0 with fifo_valid=1 -> fifo_rd_en stays 0.
//  6 rst asserted in REQ cycle 2
//    -> reg_req=0 and busy=0 next cycle; stray reg_ack later produces no rsp.

Source files
------------

// File: rtl/cmd_exec_ctrl.sv
// cmd_exec_ctrl: pops one command at a time from a show-ahead FIFO, issues it
// as a register-bus read or write, waits for ack or timeout, then presents a
// single response to the downstream formatter. Only one command is in flight.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   en                       allow new pops (in-flight command always finishes)
//   fifo_valid/op/addr/wdata show-ahead FIFO head
//   fifo_rd_en               pop strobe (combinational, one cycle per command)
//   reg_req/we/addr/wdata    register bus request, held until ack or timeout
//   reg_ack, reg_rdata       bus completion pulse and read data
//   rsp_valid/ready          response handshake
//   rsp_status, rsp_data     00 OK, 01 TIMEOUT, 10 BAD_OP; read data or 0
//   busy                     controller not idle
//   timeout_cnt              saturating count of TIMEOUT responses
module cmd_exec_ctrl #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_valid,
    input  logic [1:0]        fifo_op,
    input  logic [ADDR_W-1:0] fifo_addr,
    input  logic [DATA_W-1:0] fifo_wdata,
    output logic              fifo_rd_en,
    output logic              reg_req,
    output logic              reg_we,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic              reg_ack,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_status,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic [7:0]        timeout_cnt
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_BAD_OP  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e              state_q,       state_d;
    logic                reg_req_q,     reg_req_d;
    logic                reg_we_q,      reg_we_d;
    logic [ADDR_W-1:0]   reg_addr_q,    reg_addr_d;
    logic [DATA_W-1:0]   reg_wdata_q,   reg_wdata_d;
    logic                rsp_valid_q,   rsp_valid_d;
    logic [1:0]          rsp_status_q,  rsp_status_d;
    logic [DATA_W-1:0]   rsp_data_q,    rsp_data_d;
    logic                busy_q,        busy_d;
    logic [7:0]          timeout_cnt_q, timeout_cnt_d;
    logic [TMR_W-1:0]    timer_q,       timer_d;
    logic                pop_c;

    // Pop is a pure decode of idle state and the FIFO head; the bus latch
    // captures the head on the same edge.
    assign pop_c      = (state_q == S_IDLE) && en && fifo_valid;
    assign fifo_rd_en = pop_c;

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        reg_req_d     = reg_req_q;
        reg_we_d      = reg_we_q;
        reg_addr_d    = reg_addr_q;
        reg_wdata_d   = reg_wdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_status_d  = rsp_status_q;
        rsp_data_d    = rsp_data_q;
        timeout_cnt_d = timeout_cnt_q;
        timer_d       = timer_q;

        case (state_q)
            S_IDLE: begin
                if (pop_c) begin
                    reg_we_d    = (fifo_op == 2'b01);
                    reg_addr_d  = fifo_addr;
                    reg_wdata_d = fifo_wdata;
                    if (fifo_op[1]) begin
                        // Illegal opcode: respond directly, never touch the bus
                        state_d      = S_RESP;
                        rsp_valid_d  = 1'b1;
                        rsp_status_d = ST_BAD_OP;
                        rsp_data_d   = '0;
                    end else begin
                        state_d   = S_REQ;
                        reg_req_d = 1'b1;
                        timer_d   = '0;
                    end
                end
            end

            S_REQ: begin
                // timer_q holds (REQ cycle number - 1)
                timer_d = timer_q + TMR_W'(1);
                if (reg_ack) begin
                    // Ack wins even in the final allowed cycle
                    state_d      = S_RESP;
                    reg_req_d    = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = ST_OK;
                    rsp_data_d   = reg_we_q ? '0 : reg_rdata;
                end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                    state_d      = S_RESP;
                    reg_req_d    = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = ST_TIMEOUT;
                    rsp_data_d   = '0;
                    if (timeout_cnt_q != 8'hFF) begin
                        timeout_cnt_d = timeout_cnt_q + 8'd1;
                    end
                end
            end

            S_RESP: begin
                if (rsp_ready) begin
                    state_d      = S_IDLE;
                    rsp_valid_d  = 1'b0;
                    rsp_status_d = ST_OK;
                    rsp_data_d   = '0;
                end
            end

            default: begin
                state_d     = S_IDLE;
                reg_req_d   = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            reg_req_q     <= 1'b0;
            reg_we_q      <= 1'b0;
            reg_addr_q    <= '0;
            reg_wdata_q   <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_status_q  <= ST_OK;
            rsp_data_q    <= '0;
            busy_q        <= 1'b0;
            timeout_cnt_q <= 8'd0;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            reg_req_q     <= reg_req_d;
            reg_we_q      <= reg_we_d;
            reg_addr_q    <= reg_addr_d;
            reg_wdata_q   <= reg_wdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_status_q  <= rsp_status_d;
            rsp_data_q    <= rsp_data_d;
            busy_q        <= busy_d;
            timeout_cnt_q <= timeout_cnt_d;
            timer_q       <= timer_d;
        end
    end

    assign reg_req     = reg_req_q;
    assign reg_we      = reg_we_q;
    assign reg_addr    = reg_addr_q;
    assign reg_wdata   = reg_wdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_status  = rsp_status_q;
    assign rsp_data    = rsp_data_q;
    assign busy        = busy_q;
    assign timeout_cnt = timeout_cnt_q;

endmodule

// File: tb/tb_cmd_exec_ctrl.sv
// Directed testbench for cmd_exec_ctrl (TIMEOUT_CYC = 16).
module tb_cmd_exec_ctrl;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TO_CYC = 16;

    logic              clk;
    logic              rst;
    logic              en;
    logic              fifo_valid;
    logic [1:0]        fifo_op;
    logic [ADDR_W-1:0] fifo_addr;
    logic [DATA_W-1:0] fifo_wdata;
    logic              fifo_rd_en;
    logic              reg_req;
    logic              reg_we;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wdata;
    logic              reg_ack;
    logic [DATA_W-1:0] reg_rdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_status;
    logic [DATA_W-1:0] rsp_data;
    logic              busy;
    logic [7:0]        timeout_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    cmd_exec_ctrl #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_valid (fifo_valid),
        .fifo_op    (fifo_op),
        .fifo_addr  (fifo_addr),
        .fifo_wdata (fifo_wdata),
        .fifo_rd_en (fifo_rd_en),
        .reg_req    (reg_req),
        .reg_we     (reg_we),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_ack    (reg_ack),
        .reg_rdata  (reg_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_status (rsp_status),
        .rsp_data   (rsp_data),
        .busy       (busy),
        .timeout_cnt(timeout_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_head(input logic v, input logic [1:0] op,
                            input logic [7:0] a, input logic [31:0] d);
        fifo_valid = v;
        fifo_op    = op;
        fifo_addr  = a;
        fifo_wdata = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; reg_ack = 1'b0; reg_rdata = '0; rsp_ready = 1'b0;
        set_head(1'b0, 2'b00, 8'h00, 32'h0);
        step(); step();
        rst = 1'b0;
        n_checks++;
        if ({fifo_rd_en, reg_req, reg_we, rsp_valid, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: rd_en/req/we/rsp_valid/busy = %b, expected 00000",
                     {fifo_rd_en, reg_req, reg_we, rsp_valid, busy});
        end
        n_checks++;
        if (reg_addr !== 8'h0 || reg_wdata !== 32'h0 || rsp_status !== 2'b00 ||
            rsp_data !== 32'h0 || timeout_cnt !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h wdata=%h st=%b data=%h tcnt=%0d, expected all 0",
                     reg_addr, reg_wdata, rsp_status, rsp_data, timeout_cnt);
        end
    endtask

    task automatic test_write();
        int req_cyc = 0;
        en = 1'b1; rsp_ready = 1'b1;
        set_head(1'b1, 2'b01, 8'h10, 32'hDEADBEEF);
        #1;
        n_checks++;
        if (fifo_rd_en !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_pop: fifo_rd_en=%b, expected 1", fifo_rd_en);
        end
        step();
        set_head(1'b0, 2'b00, 8'h00, 32'h0);
        // Ack in REQ cycle 3
        for (int k = 1; k <= 3; k++) begin
            if (reg_req === 1'b1 && reg_we === 1'b1 && reg_addr === 8'h10 &&
                reg_wdata === 32'hDEADBEEF && fifo_rd_en === 1'b0)
                req_cyc++;
            reg_ack = (k == 3);
            step();
            reg_ack = 1'b0;
        end
        n_checks++;
        if (req_cyc != 3 || reg_req !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_req: good req cycles=%0d req_after=%b, expected 3 and 0",
                     req_cyc, reg_req);
        end
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_status !== 2'b00 || rsp_data !== 32'h0) begin
            n_fail++;
            $display("FAIL wr_rsp: valid=%b st=%b data=%h, expected 1 00 00000000",
                     rsp_valid, rsp_status, rsp_data);
        end
        step();
        n_checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_done: valid=%b busy=%b, expected 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_read_zero_wait();
        set_head(1'b1, 2'b00, 8'h04, 32'h0);
        step();
        set_head(1'b0, 2'b00, 8'h00, 32'h0);
        n_checks++;
        if (reg_req !== 1'b1 || reg_we !== 1'b0 || reg_addr !== 8'h04 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_req: req=%b we=%b addr=%h valid=%b, expected 1 0 04 0",
                     reg_req, reg_we, reg_addr, rsp_valid);
        end
        reg_ack = 1'b1; reg_rdata = 32'h12345678;
        step();
        reg_ack = 1'b0; reg_rdata = 32'hFFFFFFFF;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_status !== 2'b00 || rsp_data !== 32'h12345678) begin
            n_fail++;
            $display("FAIL rd_rsp: valid=%b st=%b data=%h, expected 1 00 12345678",
                     rsp_valid, rsp_status, rsp_data);
        end
        step();
    endtask

    // Runs one READ with no ack; returns number of reg_req cycles observed
    task automatic run_timeout(output int req_cyc);
        req_cyc = 0;
        set_head(1'b1, 2'b00, 8'h33, 32'h0);
        step();
        set_head(1'b0, 2'b00, 8'h00, 32'h0);
        while (reg_req === 1'b1 && req_cyc < 100) begin
            req_cyc++;
            step();
        end
    endtask

    task automatic test_timeout();
        int rc;
        run_timeout(rc);
        n_checks++;
        if (rc != 16) begin
            n_fail++;
            $display("FAIL to_len: reg_req cycles=%0d, expected 16", rc);
        end
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_status !== 2'b01 || rsp_data !== 32'h0 ||
            timeout_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL to_rsp: valid=%b st=%b data=%h tcnt=%0d, expected 1 01 0 1",
                     rsp_valid, rsp_status, rsp_data, timeout_cnt);
        end
        step();
        // Ack in the final (16th) cycle wins over the timeout
        set_head(1'b1, 2'b00, 8'h44, 32'h0);
        step();
        set_head(1'b0, 2'b00, 8'h00, 32'h0);
        for (int k = 1; k <= 16; k++) begin
            reg_ack = (k == 16); reg_rdata = 32'hA0A0A0A0;
            step();
        end
        reg_ack = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_status !== 2'b00 || rsp_data !== 32'hA0A0A0A0 ||
            timeout_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL to_lastack: valid=%b st=%b data=%h tcnt=%0d, expected 1 00 a0a0a0a0 1",
                     rsp_valid, rsp_status, rsp_data, timeout_cnt);
        end
        step();
        for (int i = 0; i < 299; i++) begin
            run_timeout(rc);
            if (i == 252) begin
                n_checks++;
                if (timeout_cnt !== 8'd254) begin
                    n_fail++;
                    $display("FAIL to_cnt254: timeout_cnt=%0d, expected 254", timeout_cnt);
                end
            end
            step();
        end
        n_checks++;
        if (timeout_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL to_sat: timeout_cnt=%0d, expected 255", timeout_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  q_op[$];
        logic [7:0]  q_addr[$];
        logic [31:0] q_data[$];
        logic [31:0] exp_data[3];
        int nrsp = 0, pops = 0, wait_cnt = 0, rc = 0, cyc = 0;
        logic popped;
        q_op.push_back(2'b00); q_addr.push_back(8'h20); q_data.push_back(32'h0);
        q_op.push_back(2'b01); q_addr.push_back(8'h21); q_data.push_back(32'hA5A5A5A5);
        q_op.push_back(2'b00); q_addr.push_back(8'h22); q_data.push_back(32'h0);
        exp_data[0] = 32'hC0FFEE20; exp_data[1] = 32'h0; exp_data[2] = 32'hC0FFEE22;
        while (nrsp < 3 && cyc < 300) begin
            cyc++;
            if (q_op.size() > 0) set_head(1'b1, q_op[0], q_addr[0], q_data[0]);
            else                 set_head(1'b0, 2'b00, 8'h00, 32'h0);
            // Slave acks in the second REQ cycle
            reg_ack   = reg_req && (rc == 1);
            reg_rdata = {24'hC0FFEE, reg_addr};
            rsp_ready = (wait_cnt >= 10) || (nrsp > 0);
            #1;
            popped = fifo_rd_en;
            if (fifo_rd_en === 1'b1) begin
                pops++;
                n_checks++;
                if (busy !== 1'b0 || pops != nrsp + 1) begin
                    n_fail++;
                    $display("FAIL b2b_pop: busy=%b pops=%0d responses=%0d, expected busy 0 pops %0d",
                             busy, pops, nrsp, nrsp + 1);
                end
            end
            if (rsp_valid === 1'b1) begin
                if (!rsp_ready) wait_cnt++;
                else begin
                    n_checks++;
                    if (rsp_status !== 2'b00 || rsp_data !== exp_data[nrsp]) begin
                        n_fail++;
                        $display("FAIL b2b_rsp%0d: st=%b data=%h, expected 00 %h",
                                 nrsp, rsp_status, rsp_data, exp_data[nrsp]);
                    end
                    nrsp++;
                end
            end
            rc = (reg_req && !reg_ack) ? rc + 1 : 0;
            step();
            if (popped) begin
                void'(q_op.pop_front()); void'(q_addr.pop_front()); void'(q_data.pop_front());
            end
        end
        reg_ack = 1'b0;
        set_head(1'b0, 2'b00, 8'h00, 32'h0);
        n_checks++;
        if (nrsp != 3 || pops != 3 || wait_cnt != 10) begin
            n_fail++;
            $display("FAIL b2b_total: responses=%0d pops=%0d held=%0d, expected 3 3 10",
                     nrsp, pops, wait_cnt);
        end
        rsp_ready = 1'b1;
        step();
    endtask

    task automatic test_bad_op_and_en();
        int seen_req = 0;
        set_head(1'b1, 2'b11, 8'h55, 32'h1);
        step();
        set_head(1'b0, 2'b00, 8'h00, 32'h0);
        if (reg_req === 1'b1) seen_req++;
        n_checks++;
        if (seen_req != 0 || rsp_valid !== 1'b1 || rsp_status !== 2'b10 || rsp_data !== 32'h0) begin
            n_fail++;
            $display("FAIL bad_op: req=%0d valid=%b st=%b data=%h, expected 0 1 10 0",
                     seen_req, rsp_valid, rsp_status, rsp_data);
        end
        step();
        en = 1'b0;
        set_head(1'b1, 2'b00, 8'h66, 32'h0);
        for (int i = 0; i < 5; i++) begin
            #1;
            if (fifo_rd_en !== 1'b0 || busy !== 1'b0) seen_req++;
            step();
        end
        n_checks++;
        if (seen_req != 0) begin
            n_fail++;
            $display("FAIL en_block: pop/busy cycles=%0d with en=0, expected 0", seen_req);
        end
        set_head(1'b0, 2'b00, 8'h00, 32'h0);
        en = 1'b1;
    endtask

    task automatic test_rst_mid();
        set_head(1'b1, 2'b00, 8'h77, 32'h0);
        step();
        set_head(1'b0, 2'b00, 8'h00, 32'h0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (reg_req !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: req=%b busy=%b valid=%b, expected 0 0 0",
                     reg_req, busy, rsp_valid);
        end
        reg_ack = 1'b1; reg_rdata = 32'hBAD0BAD0;
        step();
        reg_ack = 1'b0;
        step();
        n_checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_stray_ack: valid=%b busy=%b, expected 0 0", rsp_valid, busy);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_zero_wait();
        test_timeout();
        test_back_to_back();
        test_bad_op_and_en();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
